// File: rtl/cpu_pkg.sv
// cpu_pkg: values shared by the CPU instruction sequencer, its decoder and
// its benches.
//   - Opcode field encodings (3 bits).
//   - Sequencer state encoding (4 bits). States 0..7 are the normal phases.
//     HALTED sits outside that range.
//   - is_aluop(): true for opcodes that read an operand from memory.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_JMP = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_SKZ = 3'b111;

  typedef logic [3:0] state_t;

  localparam state_t ST_INST_ADDR  = 4'd0;
  localparam state_t ST_INST_FETCH = 4'd1;
  localparam state_t ST_INST_LOAD  = 4'd2;
  localparam state_t ST_IDLE       = 4'd3;
  localparam state_t ST_OP_ADDR    = 4'd4;
  localparam state_t ST_OP_FETCH   = 4'd5;
  localparam state_t ST_ALU_OP     = 4'd6;
  localparam state_t ST_STORE      = 4'd7;
  localparam state_t ST_HALTED     = 4'd8;

  // These opcodes take their operand from memory.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: Moore control FSM for a simple accumulator CPU.
//
// Each instruction normally takes eight phases. Memory wait states can
// stretch a phase. HLT parks the FSM in HALTED until a resume request.
//
// Ports
//   clk        in   system clock; the FSM changes state on the rising edge
//   rst_n      in   asynchronous reset, active low
//   opcode[2]  in   opcode field of the instruction register
//   zero       in   flag: accumulator equals zero
//   mem_ready  in   memory read data is valid; low inserts a wait state
//   resume     in   restart request; used only while HALTED
//   sel        out  1 = PC drives the address bus, 0 = operand drives it
//   rd         out  memory read strobe
//   ld_ir      out  load the instruction register
//   inc_pc     out  increment the program counter
//   ld_pc      out  load the program counter (jump)
//   ld_ac      out  load the accumulator
//   wr         out  memory write strobe
//   data_e     out  accumulator drives the data bus
//   halt       out  CPU is halted
//   phase[2]   out  current phase index, for debug
//
// state       | meaning
// ------------+---------------------------------------------------------------
// INST_ADDR   | PC placed on the address bus
// INST_FETCH  | instruction read; stays here while mem_ready is low
// INST_LOAD   | instruction register loads
// IDLE        | instruction register holds; opcode captured into op_q on exit
// OP_ADDR     | PC increments; HLT goes to HALTED from here
// OP_FETCH    | operand read for ALU ops; stays here while mem_ready is low
// ALU_OP      | SKZ skip, JMP load, STO data drive
// STORE       | accumulator load, memory write, or PC load
// HALTED      | parked until resume; phase reads 4
import cpu_pkg::*;

module cpu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       resume,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] op_q;
  logic       alu;

  assign alu = is_aluop(op_q);

  // op_q resets to HLT. After reset the FSM reaches OP_ADDR only after a
  // fresh opcode has been captured in IDLE, so this value is never decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INST_ADDR;
      op_q  <= OP_HLT;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) op_q <= opcode;
    end
  end

  always_comb begin
    state_nxt = ST_INST_ADDR;
    case (state)
      ST_INST_ADDR:  state_nxt = ST_INST_FETCH;
      ST_INST_FETCH: state_nxt = mem_ready ? ST_INST_LOAD : ST_INST_FETCH;
      ST_INST_LOAD:  state_nxt = ST_IDLE;
      ST_IDLE:       state_nxt = ST_OP_ADDR;
      ST_OP_ADDR:    state_nxt = (op_q == OP_HLT) ? ST_HALTED : ST_OP_FETCH;
      // Only a real operand read (rd high) waits for memory.
      ST_OP_FETCH:   state_nxt = (alu && !mem_ready) ? ST_OP_FETCH : ST_ALU_OP;
      ST_ALU_OP:     state_nxt = ST_STORE;
      ST_STORE:      state_nxt = ST_INST_ADDR;
      ST_HALTED:     state_nxt = resume ? ST_INST_ADDR : ST_HALTED;
      default:       state_nxt = ST_INST_ADDR;
    endcase
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    phase  = state[2:0];
    case (state)
      ST_INST_ADDR: sel = 1'b1;
      ST_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      ST_INST_LOAD, ST_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      ST_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (op_q == OP_HLT);
      end
      ST_OP_FETCH: rd = alu;
      ST_ALU_OP: begin
        rd     = alu;
        inc_pc = (op_q == OP_SKZ) && zero;
        ld_pc  = (op_q == OP_JMP);
        data_e = (op_q == OP_STO);
      end
      ST_STORE: begin
        rd     = alu;
        ld_ac  = alu;
        ld_pc  = (op_q == OP_JMP);
        wr     = (op_q == OP_STO);
        data_e = (op_q == OP_STO);
      end
      ST_HALTED: begin
        halt  = 1'b1;
        phase = 3'd4;
      end
      default: phase = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized self-checking bench for cpu_sequencer.
//
// The reference model works one instruction at a time. From the opcode, the
// zero flag, the wait counts and the halt length, it builds the list of
// expected cycles. Each cycle carries the expected phase, the expected
// strobes and the input values to drive. Inputs the model leaves free are
// randomized, so that the bench exercises the cases where the FSM must
// ignore those inputs.
import cpu_pkg::*;

module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero, mem_ready, resume;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .resume(resume), .sel(sel), .rd(rd),
    .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ac(ld_ac),
    .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  // One expected cycle. The input fields use -1 to mean "randomize".
  typedef struct {
    int         ph;
    logic [8:0] o;   // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}
    int         mr;
    int         zz;
    int         opc;
    int         rs;
    string      name;
  } ent_t;

  ent_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cnt_ld_ac, cnt_inc_pc;

  localparam logic [11:0] RESET_VEC = {3'd0, 9'b1_0000_0000};

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ov(input logic s, r, li, ip, lp, la, w, de, h);
    return {s, r, li, ip, lp, la, w, de, h};
  endfunction

  function automatic logic [11:0] observe();
    return {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
  endfunction

  task automatic push(input int ph, input logic [8:0] o, input int mr, input int zz,
                      input int opc, input int rs, input string name);
    ent_t e;
    e.ph = ph; e.o = o; e.mr = mr; e.zz = zz; e.opc = opc; e.rs = rs; e.name = name;
    q.push_back(e);
  endtask

  // Expected cycles for one instruction, written directly from the phase rules.
  task automatic build_instr(input logic [2:0] op, input logic z, input int wi,
                             input int wo, input int hl);
    logic  alu;
    string n;
    alu = is_aluop(op);
    n = $sformatf("op%0d", op);
    push(0, ov(1,0,0,0,0,0,0,0,0), -1, -1, -1, -1, n);
    for (int k = 0; k < wi; k++) push(1, ov(1,1,0,0,0,0,0,0,0), 0, -1, -1, -1, n);
    push(1, ov(1,1,0,0,0,0,0,0,0), 1, -1, -1, -1, n);
    push(2, ov(1,1,1,0,0,0,0,0,0), -1, -1, -1, -1, n);
    push(3, ov(1,1,1,0,0,0,0,0,0), -1, -1, int'(op), -1, n);
    push(4, ov(0,0,0,1,0,0,0,0,(op == OP_HLT)), -1, -1, -1, -1, n);
    if (op == OP_HLT) begin
      for (int k = 0; k < hl; k++) push(4, ov(0,0,0,0,0,0,0,0,1), -1, -1, -1, 0, n);
      push(4, ov(0,0,0,0,0,0,0,0,1), -1, -1, -1, 1, n);
      return;
    end
    if (alu) for (int k = 0; k < wo; k++) push(5, ov(0,1,0,0,0,0,0,0,0), 0, -1, -1, -1, n);
    push(5, ov(0,alu,0,0,0,0,0,0,0), alu ? 1 : -1, -1, -1, -1, n);
    push(6, ov(0,alu,0,(op == OP_SKZ) && z,(op == OP_JMP),0,0,(op == OP_STO),0),
         -1, int'(z), -1, -1, n);
    push(7, ov(0,alu,0,0,(op == OP_JMP),alu,(op == OP_STO),(op == OP_STO),0),
         -1, -1, -1, -1, n);
  endtask

  task automatic apply_one();
    ent_t e;
    e = q.pop_front();
    @(negedge clk);
    opcode    = (e.opc < 0) ? 3'($urandom_range(7)) : 3'(e.opc);
    zero      = (e.zz  < 0) ? 1'($urandom_range(1)) : 1'(e.zz);
    mem_ready = (e.mr  < 0) ? 1'($urandom_range(1)) : 1'(e.mr);
    resume    = (e.rs  < 0) ? 1'($urandom_range(1)) : 1'(e.rs);
    #1;
    check_val($sformatf("%s_ph%0d", e.name, e.ph), observe(), {3'(e.ph), e.o});
    cnt_ld_ac  += int'(ld_ac);
    cnt_inc_pc += int'(inc_pc);
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n && q.size() > 0; k++) apply_one();
  endtask

  task automatic run_all();
    while (q.size() > 0) apply_one();
  endtask

  // Assert reset now, away from any clock edge, and check that the outputs
  // change at once. Then hold reset for a few clocks and release it between
  // a rising edge and the next falling edge.
  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    #1;
    check_val({tag, "_async"}, observe(), RESET_VEC);
    repeat (3) begin
      @(negedge clk);
      #1;
      check_val({tag, "_held"}, observe(), RESET_VEC);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    q.delete();
  endtask

  initial begin
    int op, wi, wo, hl;
    logic z;
    rst_n = 1'b1; opcode = 3'd0; zero = 1'b0; mem_ready = 1'b1; resume = 1'b0;
    #1;
    reset_now("por");

    build_instr(OP_ADD, 1'b0, 0, 0, 0); run_all();
    build_instr(OP_STO, 1'b0, 0, 0, 0); run_all();
    build_instr(OP_SKZ, 1'b1, 0, 0, 0); run_all();
    build_instr(OP_SKZ, 1'b0, 0, 0, 0); run_all();
    build_instr(OP_JMP, 1'b0, 0, 0, 0); run_all();
    build_instr(OP_HLT, 1'b0, 0, 0, 20); run_all();

    cnt_ld_ac = 0; cnt_inc_pc = 0;
    build_instr(OP_LDA, 1'b0, 3, 2, 0); run_all();
    check_val("lda_ld_ac_pulses",  12'(cnt_ld_ac),  12'd1);
    check_val("lda_inc_pc_pulses", 12'(cnt_inc_pc), 12'd1);

    // Reset in the STORE phase of STO: wr must drop with no clock edge.
    build_instr(OP_STO, 1'b0, 0, 0, 0);
    run_n(8);
    #1;
    reset_now("sto_mid_store");

    // Reset during an instruction-fetch wait state.
    build_instr(OP_LDA, 1'b0, 3, 0, 0);
    run_n(3);
    reset_now("fetch_wait");

    build_instr(OP_AND, 1'b1, 1, 1, 0); run_all();

    for (int it = 0; it < 70; it++) begin
      op = $urandom_range(7);
      z  = 1'($urandom_range(1));
      wi = $urandom_range(3);
      wo = $urandom_range(3);
      hl = $urandom_range(25, 1);
      build_instr(3'(op), z, wi, wo, hl);
      if ($urandom_range(9) == 0) begin
        run_n($urandom_range(q.size() - 1, 1));
        #1;
        reset_now("rand_reset");
      end else begin
        run_all();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 The module SHALL have the port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The module SHALL have the port opcode, input, 3 bits: instruction-register opcode field (000 HLT, 001 JMP, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 SKZ).
REQ-004 The module SHALL have the port zero, input, 1 bit: accumulator-equals-zero flag.
REQ-005 The module SHALL have the port mem_ready, input, 1 bit: memory read data valid; low inserts wait states.
REQ-006 The module SHALL have the port resume, input, 1 bit: restart request from HALTED.
REQ-007 The module SHALL have the following outputs, each 1 bit: sel (1 = PC drives address, 0 = operand), rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt.
REQ-008 The module SHALL have the port phase, output, 3 bits: current phase index, for debug.

Function
REQ-009 The sequencer SHALL be a Moore FSM with states INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), HALTED.
REQ-010 Normal advance SHALL be one state per clock: 0→1→…→7→0.
REQ-011 In INST_FETCH, mem_ready=0 SHALL hold the state; advance occurs on the first edge with mem_ready=1.
REQ-012 In OP_FETCH, the mem_ready=0 hold of REQ-011 SHALL apply only when rd is asserted.
REQ-013 The opcode SHALL be sampled into an internal register (op_q) on the clock leaving IDLE; all later phases decode op_q, never the live opcode.
REQ-014 ALUOP SHALL be defined as op_q ∈ {ADD, AND, XOR, LDA}.
REQ-015 Output decode per state (all unlisted outputs 0):
- INST_ADDR: sel
- INST_FETCH: sel, rd
- INST_LOAD: sel, rd, ld_ir
- IDLE: sel, rd, ld_ir
- OP_ADDR: inc_pc; halt = (op_q==HLT)
- OP_FETCH: rd = ALUOP
- ALU_OP: rd = ALUOP; inc_pc = (op_q==SKZ && zero); ld_pc = (op_q==JMP); data_e = (op_q==STO)
- STORE: rd = ALUOP; ld_ac = ALUOP; ld_pc = (op_q==JMP); wr = (op_q==STO); data_e = (op_q==STO)
REQ-016 OP_ADDR with op_q==HLT SHALL transition to HALTED instead of OP_FETCH.
REQ-017 In HALTED, halt SHALL be 1, all other strobes 0, and phase SHALL be 4.
REQ-018 resume=1 in HALTED SHALL transition to INST_ADDR on the next edge.
REQ-019 resume SHALL be ignored in every other state.
REQ-020 inc_pc SHALL assert in exactly one cycle per wait-free phase visit; wait states SHALL repeat only rd/sel, never inc_pc, ld_pc, ld_ac or wr.
REQ-021 The SKZ zero flag SHALL be sampled in ALU_OP only.
REQ-022 wr and data_e SHALL never assert outside STO.
REQ-023 wr SHALL be a single-cycle pulse.

Reset
REQ-024 rst_n=0 SHALL force state to INST_ADDR and op_q to HLT immediately, independent of clk, including mid-instruction and during wait states.
REQ-025 While rst_n=0, outputs SHALL be sel=1, phase=0, and all other outputs 0.
REQ-026 The first phase advance SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-027 Opcode constants and the state encoding SHALL reside in shared package cpu_pkg, for reuse by the decoder and benches.
REQ-028 The block SHALL be a single module with no sub-module.
REQ-029 The state register and op_q SHALL be the only sequential elements.
REQ-030 Output decode SHALL be purely combinational from state, op_q and zero.

Verification
REQ-031 Reset, then ADD with mem_ready=1 → phases 0..7 in 8 clocks; rd high in phases 1,2,3,5,6,7; ld_ac high in phase 7 only; inc_pc high in phase 4 only.
REQ-032 STO → data_e high in phases 6 and 7; wr high in phase 7 only; rd low in phases 5–7.
REQ-033 SKZ with zero=1 → inc_pc high in phases 4 and 6; SKZ with zero=0 → inc_pc high in phase 4 only.
REQ-034 JMP → ld_pc high in phases 6 and 7; HLT → halt from phase 4 onward, state holds for 20 clocks; resume pulse → phase 0 on the next edge.
REQ-035 LDA with mem_ready=0 for 3 cycles in INST_FETCH and 2 cycles in OP_FETCH → instruction takes 13 clocks; exactly one ld_ac pulse and one inc_pc pulse.
REQ-036 rst_n low asynchronously mid-STORE of STO → wr drops immediately without waiting for clk; after release, sequence restarts at phase 0.
